// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MDU_W        = 32;
    localparam int unsigned MDU_ITER_DEF = 32;
    localparam logic [MDU_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_t;

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
interface mdu_if;
    import mdu_pkg::*;

    logic             start;
    logic [2:0]       op;
    logic [MDU_W-1:0] src_a;
    logic [MDU_W-1:0] src_b;
    logic             busy;
    logic             done;
    logic [MDU_W-1:0] hi;
    logic [MDU_W-1:0] lo;

    modport master (output start, op, src_a, src_b, input  busy, done, hi, lo);
    modport slave  (input  start, op, src_a, src_b, output busy, done, hi, lo);

endinterface

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Define MDU_DIV_EN to build the restoring divider; otherwise DIV/DIVU complete at once with HI/LO untouched.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MDU_ITER = MDU_ITER_DEF
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(MDU_ITER + 1);

    mdu_state_t         r_state;
    mdu_state_t         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*MDU_W-1:0] r_sr;
    logic [MDU_W-1:0]   r_opnd;
    logic [MDU_W-1:0]   r_hi;
    logic [MDU_W-1:0]   r_lo;
    logic               r_neg_q;

    logic               w_idle;
    logic               w_issue;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [MDU_W-1:0]   w_a_abs;
    logic [MDU_W-1:0]   w_b_abs;
    logic [MDU_W:0]     w_sum;
    logic [2*MDU_W-1:0] w_mul_step;
    logic [2*MDU_W-1:0] w_prod;

`ifdef MDU_DIV_EN
    logic               r_is_div;
    logic               r_neg_r;
    logic               r_dz;
    logic               w_b_zero;
    logic [MDU_W:0]     w_diff;
    logic [2*MDU_W-1:0] w_div_step;
`endif

    assign w_idle   = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_issue  = w_idle && bus.start;
    assign w_is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign w_is_div = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign w_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign w_a_neg  = w_signed && bus.src_a[MDU_W-1];
    assign w_b_neg  = w_signed && bus.src_b[MDU_W-1];
    assign w_a_abs  = w_a_neg ? -bus.src_a : bus.src_a;
    assign w_b_abs  = w_b_neg ? -bus.src_b : bus.src_b;

    // Shift-add step: low half holds the multiplier, high half accumulates.
    assign w_sum      = {1'b0, r_sr[2*MDU_W-1:MDU_W]} + (r_sr[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_step = {w_sum, r_sr[MDU_W-1:1]};
    assign w_prod     = r_neg_q ? -r_sr : r_sr;

`ifdef MDU_DIV_EN
    // Restoring step: shift {rem, dividend} left and try subtracting the divisor.
    assign w_b_zero   = (bus.src_b == '0);
    assign w_diff     = r_sr[2*MDU_W-1:MDU_W-1] - {1'b0, r_opnd};
    assign w_div_step = w_diff[MDU_W] ? {r_sr[2*MDU_W-2:0], 1'b0}
                                      : {w_diff[MDU_W-1:0], r_sr[MDU_W-2:0], 1'b1};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                if (bus.start && w_is_mul) begin
                    w_state_nxt = S_RUN;
                end else if (bus.start && w_is_div) begin
`ifdef MDU_DIV_EN
                    w_state_nxt = S_RUN;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
            S_RUN:   if (r_cnt == '0) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_sr    <= '0;
            r_opnd  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_neg_q <= 1'b0;
`ifdef MDU_DIV_EN
            r_is_div <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
`endif
        end else if (w_issue) begin
            if (w_is_mul) begin
                r_cnt   <= CNT_W'(MDU_ITER - 1);
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_opnd  <= w_a_abs;
                r_sr    <= {{MDU_W{1'b0}}, w_b_abs};
`ifdef MDU_DIV_EN
                r_is_div <= 1'b0;
            end else if (w_is_div) begin
                // Divide by zero keeps the raw dividend so the remainder comes out as src_a.
                r_cnt    <= CNT_W'(MDU_ITER - 1);
                r_is_div <= 1'b1;
                r_dz     <= w_b_zero;
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_opnd   <= w_b_abs;
                r_sr     <= {{MDU_W{1'b0}}, (w_b_zero ? bus.src_a : w_a_abs)};
`endif
            end else if (bus.op == OP_MTHI) begin
                r_hi <= bus.src_a;
            end else if (bus.op == OP_MTLO) begin
                r_lo <= bus.src_a;
            end
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - CNT_W'(1);
`ifdef MDU_DIV_EN
            r_sr  <= r_is_div ? w_div_step : w_mul_step;
`else
            r_sr  <= w_mul_step;
`endif
        end else if (r_state == S_FIX) begin
`ifdef MDU_DIV_EN
            if (r_is_div) begin
                if (r_dz) begin
                    r_hi <= r_sr[2*MDU_W-1:MDU_W];
                    r_lo <= DIV0_QUOT;
                end else begin
                    r_hi <= r_neg_r ? -r_sr[2*MDU_W-1:MDU_W] : r_sr[2*MDU_W-1:MDU_W];
                    r_lo <= r_neg_q ? -r_sr[MDU_W-1:0] : r_sr[MDU_W-1:0];
                end
            end else
`endif
            begin
                {r_hi, r_lo} <= w_prod;
            end
        end
    end

    assign bus.busy = (r_state == S_RUN) || (r_state == S_FIX);
    assign bus.done = (r_state == S_DONE);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
